// File: rtl/lift_req_queue.sv
// Request FIFO and offer/ack handshake feeding the lift controller FSM.
// Drops illegal and duplicate call codes; flags requests lost to a full queue.
module lift_req_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [2:0]    req_code,
    input  logic          done,
    output logic [2:0]    din,
    output logic          qEmpty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OFFER = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    hold_q, hold_d;
    logic          overflow_q, overflow_d;

    logic          legal, dup, pop, push, ovf_set, full_w;
    logic [AW:0]   fill;
    logic [AW-1:0] off;

    assign legal  = (req_code != 3'b000) && (req_code != 3'b101);
    assign full_w = (count_q == CW'(DEPTH));
    assign pop    = (state_q == OFFER) && done;
    // Occupied window taken from the pointer pair; the wrap bit keeps full distinct from empty.
    assign fill   = wr_ptr_q - rd_ptr_q;

    always_comb begin
        dup = 1'b0;
        off = '0;
        if ((state_q == ACK) && (req_code == hold_q)) begin
            dup = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr_q[AW-1:0];
            if (({1'b0, off} < fill) && (mem_q[i] == req_code)) begin
                dup = 1'b1;
            end
        end
    end

    // A slot freed by this edge's pop can take a push into a full queue.
    assign push    = req_valid && legal && !dup && (!full_w || pop);
    assign ovf_set = req_valid && legal && !dup && full_w && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        din     = 3'b000;
        qEmpty  = 1'b1;
        case (state_q)
            EMPTY: begin
                if (count_q != '0) begin
                    state_d = OFFER;
                end
            end
            OFFER: begin
                qEmpty = 1'b0;
                din    = mem_q[rd_ptr_q[AW-1:0]];
                if (done) begin
                    state_d = ACK;
                    hold_d  = mem_q[rd_ptr_q[AW-1:0]];
                end
            end
            ACK: begin
                qEmpty = 1'b0;
                din    = hold_q;
                if (!done) begin
                    state_d = (count_d != '0) ? OFFER : EMPTY;
                    hold_d  = 3'b000;
                end
            end
            default: begin
                state_d = EMPTY;
                hold_d  = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= 3'b000;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= req_code;
        end
    end

    assign full     = full_w;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
